// File: rtl/cdc_2phase_pkg.sv
// Shared types and defaults for the two-phase (toggle) CDC handshake pair.
// The destination-side block reuses src_state_e for its own IDLE/BUSY tracking.
package cdc_2phase_pkg;

    // Handshake state: IDLE accepts a word, BUSY waits for the ack toggle
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } src_state_e;

    // Default depth of the ack synchronizer chain
    localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// The output lags the input by STAGES clk_i edges; all flops clear to 0.
module sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic serial_i,
    output logic serial_o
);

    logic [STAGES-1:0] reg_q;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_q <= '0;
        end else begin
            reg_q <= {reg_q[STAGES-2:0], serial_i};
        end
    end

    assign serial_o = reg_q[STAGES-1];

endmodule

// File: rtl/cdc_2phase_src.sv
// Source half of a two-phase toggle CDC handshake.
// A word accepted on valid_i/ready_o is held on async_data_o while async_req_o
// is toggled; the next word is accepted only after the destination's ack toggle
// (synchronized through SYNC_STAGES flops) matches the request level again.
// Optional feature macro: CDC_2PHASE_SRC_TIMEOUT_EN enables a sticky
// ack-timeout flag on timeout_o; without it timeout_o is tied to 0.
module cdc_2phase_src
    import cdc_2phase_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             async_req_o,
    output logic [WIDTH-1:0] async_data_o,
    input  logic             async_ack_i,
    output logic             timeout_o
);

    src_state_e       state_q, state_d;
    logic             req_q;
    logic [WIDTH-1:0] data_q;
    logic             ack_s;
    logic             accept;

    // The ack toggle is only ever touched here, at the synchronizer input
    sync #(
        .STAGES (SYNC_STAGES)
    ) i_ack_sync (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .serial_i (async_ack_i),
        .serial_o (ack_s)
    );

    // Next-state decode; ack mismatches seen in IDLE are simply ignored, so a
    // stray ack edge only shortens the following transfer and cannot deadlock
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (ack_s == req_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request toggle and payload change together, only on an accept edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q  <= 1'b0;
            data_q <= '0;
        end else if (accept) begin
            req_q  <= ~req_q;
            data_q <= data_i;
        end
    end

    // ready_o is a plain state decode so it never depends on valid_i
    assign ready_o      = (state_q == IDLE);
    assign async_req_o  = req_q;
    assign async_data_o = data_q;

`ifdef CDC_2PHASE_SRC_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    // Count BUSY cycles of the current transfer, saturating at the limit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if ((state_q == BUSY) && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Flag rises on the edge the counter reaches the limit and stays until reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timeout_q <= 1'b0;
        end else if ((state_q == BUSY) && (cnt_q == CNT_MAX - 1'b1)) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout_o          = 1'b0;
`endif

endmodule
